// File: rtl/tl_pkg.sv
// Shared constants, state type and window helper for the race-logic edge encoder.
package tl_pkg;

   localparam int W_DEF = 3;

   // All-ones value at the default width encodes "never fires".
   localparam logic [W_DEF-1:0] INF = '1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic int win_len(input int w);
      return 1 << w;
   endfunction

endpackage

// File: rtl/tl_chan_fire.sv
// One temporal output channel: compares its value against the window counter.
// TL_PULSE_MODE_EN selects a one-cycle pulse; otherwise q holds until window end.
module tl_chan_fire
   import tl_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         aclk,
   input  logic         rst,
   input  logic [W-1:0] val_i,
   input  logic [W-1:0] cnt_i,
   input  logic         grst_i,
   input  logic         win_end_i,
   output logic         q_o
);

   logic is_inf;
   logic fire;

   assign is_inf = &val_i;

   // Value 0 may only match during the grst cycle, since an idle encoder parks cnt at 0.
   assign fire = !is_inf && (cnt_i == val_i) && (grst_i || (val_i != '0));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (rst) begin
         q_o <= 1'b0;
      end
`ifdef TL_PULSE_MODE_EN
      else begin
         q_o <= fire && !win_end_i;
      end
`else
      else if (win_end_i) begin
         q_o <= 1'b0;
      end else if (fire) begin
         q_o <= 1'b1;
      end
`endif
   end

endmodule

// File: rtl/tl_edge_encoder.sv
// Binary-to-temporal encoder: handshake, pending/active vectors, window counter and FSM.
// Channel output style is selected by TL_PULSE_MODE_EN (see tl_chan_fire).
module tl_edge_encoder
   import tl_pkg::*;
#(
   parameter int N_CH = 2,
   parameter int W    = W_DEF
) (
   input  logic              aclk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_CH*W-1:0] in_val,
   output logic              grst,
   output logic [N_CH-1:0]   q,
   output logic              busy
);

   localparam logic [W-1:0] CNT_MAX = W'(win_len(W) - 1);

   state_e              state_q;
   logic [W-1:0]        cnt_q;
   logic                grst_q;
   logic                pend_vld_q;
   logic [N_CH*W-1:0]   pend_val_q;
   logic [N_CH*W-1:0]   act_val_q;

   logic                win_end;
   logic                launch;
   logic                xfer;

   assign win_end  = (state_q == RUN) && (cnt_q == CNT_MAX);
   assign launch   = pend_vld_q && ((state_q == IDLE) || win_end);
   assign in_ready = !rst && (!pend_vld_q || launch);
   assign xfer     = in_valid && in_ready;

   assign grst = grst_q;
   assign busy = (state_q == RUN);

   // Window FSM; a launch at the last window cycle restarts with no idle gap.
   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         grst_q     <= 1'b0;
         pend_vld_q <= 1'b0;
      end else begin
         grst_q <= launch;

         unique case (state_q)
            IDLE: begin
               if (launch) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               if (cnt_q == CNT_MAX) begin
                  cnt_q   <= '0;
                  state_q <= launch ? RUN : IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase

         if (xfer) begin
            pend_vld_q <= 1'b1;
         end else if (launch) begin
            pend_vld_q <= 1'b0;
         end
      end
   end

   // NOTE: data registers carry no reset; their valid flags and the FSM decide when they matter.
   always_ff @(posedge aclk) begin
      if (xfer) begin
         pend_val_q <= in_val;
      end
      if (launch) begin
         act_val_q <= pend_val_q;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      tl_chan_fire #(
         .W (W)
      ) u_chan (
         .aclk      (aclk),
         .rst       (rst),
         .val_i     (act_val_q[i*W +: W]),
         .cnt_i     (cnt_q),
         .grst_i    (grst_q),
         .win_end_i (win_end),
         .q_o       (q[i])
      );
   end

endmodule

// File: tb/tb_tl_edge_encoder.sv
// Self-checking bench for tl_edge_encoder (N_CH=2, W=3) against a window-schedule model.
module tb_tl_edge_encoder;
   import tl_pkg::*;

   localparam int N_CH = 2;
   localparam int W    = 3;
   localparam int WIN  = 8;
`ifdef TL_PULSE_MODE_EN
   localparam bit PULSE = 1'b1;
`else
   localparam bit PULSE = 1'b0;
`endif

   logic              aclk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [N_CH*W-1:0] in_val = '0;
   logic              in_ready;
   logic              grst;
   logic [N_CH-1:0]   q;
   logic              busy;

   always #5 aclk = ~aclk;

   tl_edge_encoder #(
      .N_CH (N_CH),
      .W    (W)
   ) dut (
      .aclk     (aclk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_val   (in_val),
      .grst     (grst),
      .q        (q),
      .busy     (busy)
   );

   // Each accepted vector becomes a window: accepted at edge a, grst at edge s.
   typedef struct {
      int a;
      int s;
      int v0;
      int v1;
   } win_t;

   win_t        wq[$];
   int          t = 0;
   int          errors = 0;
   int          checks = 0;
   bit          accepted;
   logic [4:0]  obs;   // {in_ready, grst, busy, q[1], q[0]}
   logic [4:0]  expv;

   // Ready unless some vector was accepted earlier and still waits for its launch edge.
   function automatic bit model_ready(input int e, input bit r);
      if (r) return 1'b0;
      foreach (wq[j]) if (wq[j].a < e && e < wq[j].s) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit fires(input int s, input int v, input int e);
      if (v == int'(INF)) return 1'b0;
      if (PULSE) return e == s + 1 + v;
      return (e >= s + 1 + v) && (e <= s + WIN - 1);
   endfunction

   function automatic logic [3:0] model_out(input int e);
      logic [3:0] o;
      o = '0;
      foreach (wq[j]) begin
         if (e == wq[j].s) o[3] = 1'b1;
         if (e >= wq[j].s && e <= wq[j].s + WIN - 1) o[2] = 1'b1;
         if (fires(wq[j].s, wq[j].v1, e)) o[1] = 1'b1;
         if (fires(wq[j].s, wq[j].v0, e)) o[0] = 1'b1;
      end
      return o;
   endfunction

   // One clock: drive at the falling edge, sample ready before and outputs after the rising edge.
   task automatic cycle(input bit v, input logic [N_CH*W-1:0] d, input bit r);
      bit rdy_m;
      int s;
      accepted = 1'b0;
      in_valid = v;
      in_val   = d;
      rst      = r;
      #1;
      rdy_m   = model_ready(t + 1, r);
      obs[4]  = in_ready;
      expv[4] = rdy_m;
      @(posedge aclk);
      t++;
      if (r) begin
         wq.delete();
      end else if (v && rdy_m) begin
         s = t + 1;
         if (wq.size() > 0 && wq[$].s + WIN > s) s = wq[$].s + WIN;
         wq.push_back('{t, s, int'(d[2:0]), int'(d[5:3])});
         accepted = 1'b1;
      end
      @(negedge aclk);
      obs[3:0]  = {grst, busy, q[1], q[0]};
      expv[3:0] = model_out(t);
   endtask

   task automatic test_reset();
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      if (obs !== expv) begin errors++; $display("FAIL reset_init t=%0d got=%b want=%b", t, obs, expv); end
      checks++;
      for (int n = 0; n < 4; n++) begin
         cycle(1'b1, {3'd4, 3'd1}, 1'b0);
         if (obs !== expv) begin errors++; $display("FAIL reset_pre t=%0d got=%b want=%b", t, obs, expv); end
         checks++;
      end
      for (int n = 0; n < 2; n++) begin
         cycle(1'b1, {3'd4, 3'd1}, 1'b1);
         if (obs[3:0] !== 4'b0000) begin errors++; $display("FAIL reset_hold t=%0d got=%b want=0000", t, obs[3:0]); end
         checks++;
      end
      cycle(1'b0, '0, 1'b0);
      if (obs[4] !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", obs[4]); end
      checks++;
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 12; n++) begin
         cycle(1'b0, '0, 1'b0);
         if (obs !== expv) begin errors++; $display("FAIL %s_drain t=%0d got=%b want=%b", name, t, obs, expv); end
         checks++;
      end
   endtask

   task automatic test_level_vector();
      int k;
      drain("vec25");
      cycle(1'b1, {3'd5, 3'd2}, 1'b0);
      if (accepted !== 1'b1 || obs !== expv) begin errors++; $display("FAIL vec25_accept got=%b want=%b", obs, expv); end
      checks++;
      k = t;
      for (int n = 1; n <= 10; n++) begin
         cycle(1'b0, '0, 1'b0);
         if (obs !== expv) begin errors++; $display("FAIL vec25 t=k+%0d got=%b want=%b", n, obs, expv); end
         checks++;
         if (t == k + 1 && grst !== 1'b1) begin errors++; $display("FAIL vec25_grst got=%b want=1", grst); end
         if (t == k + 4 && q[0] !== 1'b1) begin errors++; $display("FAIL vec25_q0_rise got=%b want=1", q[0]); end
         if (t == k + 5 && q[0] !== !PULSE) begin errors++; $display("FAIL vec25_q0_after got=%b want=%b", q[0], !PULSE); end
         if (t == k + 7 && q[1] !== 1'b1) begin errors++; $display("FAIL vec25_q1_rise got=%b want=1", q[1]); end
         if (t == k + 9 && {busy, q} !== 3'b000) begin errors++; $display("FAIL vec25_end got=%b want=000", {busy, q}); end
         if (t == k + 1 || t == k + 4 || t == k + 5 || t == k + 7 || t == k + 9) checks++;
      end
   endtask

   task automatic test_equal_inf();
      logic [5:0] vecs[3];
      int         fire_n[3];
      logic [1:0] fire_q[3];
      int         k;
      vecs   = '{{3'd3, 3'd3}, {3'd0, 3'd7}, {3'd6, 3'd6}};
      fire_n = '{5, 2, 8};
      fire_q = '{2'b11, 2'b10, 2'b11};
      for (int j = 0; j < 3; j++) begin
         drain("eqinf");
         cycle(1'b1, vecs[j], 1'b0);
         if (accepted !== 1'b1) begin errors++; $display("FAIL eqinf_accept vec=%0d got=0 want=1", j); end
         checks++;
         k = t;
         for (int n = 1; n <= 9; n++) begin
            cycle(1'b0, '0, 1'b0);
            if (obs !== expv) begin errors++; $display("FAIL eqinf vec=%0d t=k+%0d got=%b want=%b", j, n, obs, expv); end
            checks++;
            if (t == k + fire_n[j]) begin
               if (q !== fire_q[j]) begin errors++; $display("FAIL eqinf_fire vec=%0d got=%b want=%b", j, q, fire_q[j]); end
               checks++;
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] vecs[3];
      int         idx;
      int         k;
      vecs = '{{3'd5, 3'd2}, {3'd1, 3'd6}, {3'd7, 3'd0}};
      idx  = 0;
      k    = -100;
      drain("b2b");
      for (int n = 0; n < 30; n++) begin
         cycle(idx < 3, (idx < 3) ? vecs[idx] : 6'd0, 1'b0);
         if (accepted) begin
            if (idx == 0) k = t;
            idx++;
         end
         if (obs !== expv) begin errors++; $display("FAIL b2b t=%0d got=%b want=%b", t, obs, expv); end
         checks++;
         if (t == k + 1 || t == k + 9 || t == k + 17) begin
            if (grst !== 1'b1) begin errors++; $display("FAIL b2b_grst t=k+%0d got=%b want=1", t - k, grst); end
            checks++;
         end
      end
      if (idx != 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", idx); end
      checks++;
   endtask

   task automatic test_reset_mid();
      int k;
      drain("rstmid");
      cycle(1'b1, {3'd5, 3'd2}, 1'b0);
      k = t;
      cycle(1'b1, {3'd1, 3'd1}, 1'b0);
      if (accepted !== 1'b1) begin errors++; $display("FAIL rstmid_pending got=0 want=1"); end
      checks++;
      while (t < k + 4) begin
         cycle(1'b0, '0, 1'b0);
         if (obs !== expv) begin errors++; $display("FAIL rstmid_pre t=%0d got=%b want=%b", t, obs, expv); end
         checks++;
      end
      cycle(1'b0, '0, 1'b1);
      for (int n = 0; n < 12; n++) begin
         cycle(1'b0, '0, 1'b0);
         if (obs[3:0] !== 4'b0000) begin errors++; $display("FAIL rstmid_quiet t=%0d got=%b want=0000", t, obs[3:0]); end
         checks++;
      end
   endtask

   task automatic test_random();
      bit         v;
      bit         r;
      logic [5:0] d;
      for (int n = 0; n < 400; n++) begin
         v = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 49) == 0);
         d = 6'($urandom);
         cycle(v, d, r);
         if (obs !== expv) begin errors++; $display("FAIL random t=%0d got=%b want=%b", t, obs, expv); end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_level_vector();
      test_equal_inf();
      test_back_to_back();
      test_reset_mid();
      test_random();
      drain("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tl_edge_encoder.md
# tl_edge_encoder

Binary-to-temporal encoder for the race-logic datapath: accepts a vector of small unsigned values over a valid/ready handshake and replays each value as an edge on its own output line, timed relative to a gamma-cycle reset. It drives the temporal primitives (`less_than` and similar) and supplies the `grst` they consume. Per-channel event time is proportional to the value. The all-ones value encodes "never" (infinity).

## Interface
- `N_CH`, 2: number of temporal output channels.
- `W`, 3: value width; gamma window is 2**W cycles; value 2**W-1 = INF.
- `aclk` in 1: the single clock.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: input vector valid.
- `in_ready` out 1: encoder can accept a vector.
- `in_val` in N_CH*W: channel i value at bits [i*W +: W].
- `grst` out 1: gamma reset, one-cycle pulse at the start of each window.
- `q` out N_CH: temporal outputs, one per channel.
- `busy` out 1: a window is in progress.

## Operation
- Storage:
  - Pending register (`pend_val`, `pend_vld`): holds one accepted vector.
  - Active register: holds the vector being replayed.
  - Window counter `cnt`, width W.
- States: IDLE, RUN.
- Handshake:
  - `in_ready = !rst && (!pend_vld || launch)`.
  - A transfer occurs when `in_valid && in_ready`.
  - Accept and launch in the same cycle: pending is consumed and refilled in that cycle.
- `launch` is true when `pend_vld` is set and either the state is IDLE, or the state is RUN with `cnt == 2**W-1`.
- On launch, the next cycle:
  - active register ← pending; `pend_vld` clears unless refilled.
  - `grst` = 1, `cnt` = 0, state = RUN.
- RUN window, cycles `cnt` = 0 .. 2**W-1:
  - Channel i with value v ≠ INF fires at `cnt == v+1`.
  - INF never fires.
  - Value 2**W-2 fires on the last window cycle.
- At the end of the window (`cnt == 2**W-1`): the next cycle either relaunches (no gap) or the state returns to IDLE.
- `busy` = (state == RUN).
- Reset values: `q` = 0, `grst` = 0, `busy` = 0, `pend_vld` = 0, state = IDLE, `cnt` = 0.
- Reset mid-window:
  - All outputs go to 0 in the cycle after `rst` is sampled high.
  - Pending and active data are discarded.
  - No partial window resumes.

## Timing
- All outputs except `in_ready` are registered.
- Transfer accepted at cycle k while IDLE gives `grst` = 1 at k+1.
- Channel with value v: output event at k+2+v.
- Window occupies k+1 .. k+2**W.
- Level mode: `q[i]` clears at k+2**W+1, which coincides with the next `grst` on back-to-back windows.
- Back-to-back windows: the second `grst` directly follows the last window cycle, with zero idle cycles.
- Throughput: one vector per 2**W cycles.
- Simultaneous equal values: channels rise in the same cycle.

## Configuration
- `TL_PULSE_MODE_EN`:
  - Defined: `q[i]` is a single-cycle pulse at the fire cycle (pulse-width encoding).
  - Undefined: `q[i]` rises at the fire cycle and holds until the window ends (rising-edge encoding); it is 0 at every `grst` cycle.
- Handshake and `grst` timing are identical in both modes.

## Structure
- Package `tl_pkg`:
  - Default `W`.
  - `INF` as the all-ones W-bit constant.
  - State enum {IDLE, RUN}.
  - Function for window length 2**W.
- Sub-module `tl_chan_fire`, one per channel:
  - Inputs: `aclk`, `rst`, value, `cnt`, `grst`, window-end.
  - Owns the compare against `cnt`, the INF gating and the `q` register, including the mode macro.
- The top level owns the handshake, pending/active registers, counter and FSM.

## Test plan
All tests use `N_CH`=2, `W`=3 (window 8, INF=7).
- Reset: hold `rst` 2 cycles mid-stream → `q`=0, `grst`=0, `busy`=0; `in_ready`=1 in the cycle after `rst` falls.
- Level mode, vector {2,5} accepted at k:
  - `grst` at k+1.
  - `q[0]` rises at k+4; `q[1]` rises at k+7.
  - Both clear at k+9; `busy` is low at k+9.
- Pulse mode, vector {2,5}: `q[0]` high only at k+4; `q[1]` high only at k+7.
- Equal and infinity:
  - {3,3}: both rise at k+5.
  - {7,0}: `q[1]` rises at k+2; `q[0]` stays 0 all window.
  - {6,6}: both fire at k+8.
- Back-to-back, `in_valid` held with three vectors:
  - `grst` at k+1, k+9, k+17.
  - `in_ready` is low while pending is full and high in each launch cycle.
- Reset at k+4 during {2,5} with a pending vector: from k+5, all outputs are 0, `busy` is 0, and no `grst` follows until a new transfer.
